transfer_counter_reg: RTL and testbench
=======================================

# transfer_counter_reg

Parametrised, clocked successor to the transfer register. It holds one DATA_W-bit word that can be loaded either whole from the transfer bus or per byte lane from the main bus, and counted up or down in place. It drives its contents onto the address bus, the transfer bus, or any single main-bus byte lane through tristate outputs. It sits on the CPU's transfer path as a pointer/length register for block copies, where post-increment and decrement remove an ALU round-trip.

## Interface
Parameters:
- DATA_W, default 16: register and transfer/address bus width; must be a multiple of MAIN_W.
- MAIN_W, default 8: main bus width, i.e. one byte lane.
- LANES, default DATA_W/MAIN_W: derived, not overridden; lane 0 is least significant.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Addr  out  DATA_W  tristate; drives the register when a_tx_addr_n=0, otherwise Z.
- Bus  inout  DATA_W  transfer bus; load source, and tristate output.
- MainBus  inout  MAIN_W  main bus; per-lane load source, and tristate output.
- l_lane_n  in  LANES  active-low, per lane: load MainBus into lane i.
- a_lane_n  in  LANES  active-low, per lane: drive lane i onto MainBus.
- l_tx_n  in  1  active-low: load the whole word from Bus.
- a_tx_addr_n  in  1  active-low: drive Addr.
- a_tx_xfer_n  in  1  active-low: drive Bus.
- inc_n, dec_n  in  1  active-low: add or subtract 1, modulo 2^DATA_W.
- zero  out  1  combinational; high when the register is 0.
- wrap  out  1  registered; one-cycle pulse after an increment from all-ones or a decrement from 0.
- conflict  out  1  sticky; set when more than one a_lane_n is low on a clock edge.

## Operation
- Write priority at each rising edge:
  - l_tx_n low: load Bus; all lane loads and counting ignored.
  - else any l_lane_n low: each selected lane loads MainBus; other lanes hold; counting ignored.
  - else inc_n low XOR dec_n low: count by 1. If both are low, hold.
  - else hold.
- wrap is set only on a counting edge that wraps; every other edge clears it.
- Output drivers (combinational from the current register, qualified by rst_n):
  - Addr = reg when a_tx_addr_n=0 and rst_n=1, else Z.
  - Bus = reg when a_tx_xfer_n=0, l_tx_n=1 and rst_n=1, else Z. The block never drives the bus it is loading from.
  - MainBus = lowest-index lane whose a_lane_n=0. It is not driven while any l_lane_n is low, and is Z during reset.
- conflict is set at any edge where two or more a_lane_n are low. It clears only on reset.
- Reset (asynchronous, at any time, including mid-count or mid-load) gives reg=0, wrap=0, conflict=0, zero=1, all buses Z. Released controls take effect from the first edge after rst_n rises.

## Timing
- Load and count latency is 1 clock: the new value appears on drivers and zero right after the edge.
- An assert in the same cycle as a load or count presents the old value until the edge. This makes "assert Addr + inc_n" a post-increment.
- Output enable and disable are purely combinational with no cycle delay. Bench sampling is mid-cycle.
- wrap is valid for exactly the one cycle after the wrapping edge.

## Structure
- Shared package transfer_pkg:
  - DATA_W/MAIN_W defaults.
  - lane_count function.
  - Elaboration check that DATA_W % MAIN_W == 0; a non-multiple is a fatal error.
- One sub-module, tristate_drv (param W; in data, in en_n, out/inout pad). It is instantiated once for Addr, once for Bus, and once per lane onto MainBus via the priority-qualified enable.
- Register, priority logic and flags live in the top module.

## Test plan
- Reset, then pulse l_lane_n[1] with MainBus=8'h55, then l_lane_n[0] with 8'hAA. Next, a_tx_addr_n=0 gives Addr=16'h55AA; with all asserts high, Addr and Bus are Z.
- Drive Bus=16'h1234 with l_tx_n=0 and l_lane_n[0]=0 (MainBus=8'hFF) in the same cycle: reg=16'h1234 (transfer load wins). Then a_lane_n[1]=0 gives MainBus=8'h12.
- Load 16'hFFFF, then inc_n one cycle: reg=0, zero=1, wrap=1 for one cycle. Then dec_n: reg=16'hFFFF, wrap=1. Both inc_n and dec_n low: reg holds, wrap=0.
- With a_tx_addr_n=0 and inc_n=0 for 3 cycles starting from 16'h0100: Addr reads 0100, 0101, 0102, then 0103 after the last edge.
- a_lane_n=2'b00 for one edge: MainBus=lane 0, conflict=1 and stays 1 after release until rst_n pulse.
- Assert rst_n low mid-count with inc_n held low and a_tx_xfer_n=0: immediately reg=0, Bus=Z, wrap=0. After release, counting resumes from 0 to 1 on the first edge.

Source files
------------

// File: rtl/transfer_pkg.sv
// Shared widths and helpers for the transfer counter register.
package transfer_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int MAIN_W_DEF = 8;

    function automatic int lane_count(input int data_w, input int main_w);
        return data_w / main_w;
    endfunction

    // The register must split into whole main-bus lanes.
    function automatic bit widths_ok(input int data_w, input int main_w);
        return (main_w > 0) && (data_w % main_w == 0);
    endfunction

endpackage

// File: rtl/transfer_counter_reg_if.sv
// Control strobes and status flags of the transfer counter register.
interface transfer_counter_reg_if #(
    parameter int LANES = 2
);
    // All strobes are active-low levels, sampled on the rising clock edge;
    // there is no handshake, the register accepts every strobe immediately.
    logic [LANES-1:0] l_lane_n;
    logic [LANES-1:0] a_lane_n;
    logic             l_tx_n;
    logic             a_tx_addr_n;
    logic             a_tx_xfer_n;
    logic             inc_n;
    logic             dec_n;
    logic             zero;
    logic             wrap;
    logic             conflict;

    modport master (
        output l_lane_n, a_lane_n, l_tx_n, a_tx_addr_n, a_tx_xfer_n, inc_n, dec_n,
        input  zero, wrap, conflict
    );

    modport slave (
        input  l_lane_n, a_lane_n, l_tx_n, a_tx_addr_n, a_tx_xfer_n, inc_n, dec_n,
        output zero, wrap, conflict
    );

endinterface

// File: rtl/transfer_counter_reg_tristate_drv.sv
// Active-low enabled tristate driver onto a shared pad.
module tristate_drv #(
    parameter int W = 8
) (
    input  logic [W-1:0] data,
    input  logic         en_n,
    output wire  [W-1:0] pad
);

    assign pad = en_n ? {W{1'bz}} : data;

endmodule

// File: rtl/transfer_counter_reg.sv
// Loadable up/down transfer register with tristate drivers onto the
// address, transfer and per-lane main buses.
module transfer_counter_reg
    import transfer_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int MAIN_W = MAIN_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output wire  [DATA_W-1:0]     Addr,
    inout  wire  [DATA_W-1:0]     Bus,
    inout  wire  [MAIN_W-1:0]     MainBus,
    transfer_counter_reg_if.slave ctl
);

    localparam int LANES = lane_count(DATA_W, MAIN_W);
    localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

    if (!widths_ok(DATA_W, MAIN_W)) begin : g_width_check
        $fatal(1, "transfer_counter_reg: DATA_W must be a multiple of MAIN_W");
    end

    logic [DATA_W-1:0] reg_q;
    logic [DATA_W-1:0] reg_d;
    logic              wrap_q;
    logic              wrap_d;
    logic              conflict_q;
    logic              lane_clash;
    logic [LANES-1:0]  lane_en_n;
    logic              lane_found;

    // Load beats lane load beats counting; simultaneous inc and dec cancel.
    always_comb begin
        reg_d  = reg_q;
        wrap_d = 1'b0;
        if (!ctl.l_tx_n) begin
            reg_d = Bus;
        end else if (!(&ctl.l_lane_n)) begin
            for (int i = 0; i < LANES; i++) begin
                if (!ctl.l_lane_n[i]) begin
                    reg_d[i*MAIN_W +: MAIN_W] = MainBus;
                end
            end
        end else if (ctl.inc_n != ctl.dec_n) begin
            if (!ctl.inc_n) begin
                reg_d  = reg_q + ONE;
                wrap_d = &reg_q;
            end else begin
                reg_d  = reg_q - ONE;
                wrap_d = ~|reg_q;
            end
        end
    end

    assign lane_clash = ($countones(~ctl.a_lane_n) > 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_q      <= '0;
            wrap_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            reg_q      <= reg_d;
            wrap_q     <= wrap_d;
            conflict_q <= conflict_q | lane_clash;
        end
    end

    assign ctl.zero     = (reg_q == '0);
    assign ctl.wrap     = wrap_q;
    assign ctl.conflict = conflict_q;

    // Only the lowest requested lane drives, and never while a lane is loading.
    always_comb begin
        lane_en_n  = '1;
        lane_found = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (!lane_found && !ctl.a_lane_n[i]) begin
                lane_found = 1'b1;
                if (rst_n && (&ctl.l_lane_n)) begin
                    lane_en_n[i] = 1'b0;
                end
            end
        end
    end

    tristate_drv #(.W(DATA_W)) u_addr_drv (
        .data (reg_q),
        .en_n (ctl.a_tx_addr_n | ~rst_n),
        .pad  (Addr)
    );

    tristate_drv #(.W(DATA_W)) u_bus_drv (
        .data (reg_q),
        .en_n (ctl.a_tx_xfer_n | ~ctl.l_tx_n | ~rst_n),
        .pad  (Bus)
    );

    for (genvar g = 0; g < LANES; g++) begin : g_lane_drv
        tristate_drv #(.W(MAIN_W)) u_lane_drv (
            .data (reg_q[g*MAIN_W +: MAIN_W]),
            .en_n (lane_en_n[g]),
            .pad  (MainBus)
        );
    end

endmodule

// File: tb/tb_transfer_counter_reg.sv
// Bench for transfer_counter_reg: directed vector table, corner sequences
// and a randomized run against an arithmetic reference model.
module tb_transfer_counter_reg;

    localparam int DW = 16;
    localparam int MW = 8;
    localparam logic [DW-1:0] ZD = 16'hFFFF;  // undriven bus reads high via pullups
    localparam logic [MW-1:0] ZM = 8'hFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wire [DW-1:0] addr_w;
    wire [DW-1:0] bus_w;
    wire [MW-1:0] main_w;

    logic [DW-1:0] bus_drv = '0;
    logic          bus_drv_en = 1'b0;
    logic [MW-1:0] main_drv = '0;
    logic          main_drv_en = 1'b0;

    assign bus_w  = bus_drv_en  ? bus_drv  : {DW{1'bz}};
    assign main_w = main_drv_en ? main_drv : {MW{1'bz}};

    for (genvar g = 0; g < DW; g++) begin : g_pu_d
        pullup (addr_w[g]);
        pullup (bus_w[g]);
    end
    for (genvar g = 0; g < MW; g++) begin : g_pu_m
        pullup (main_w[g]);
    end

    transfer_counter_reg_if #(.LANES(2)) ctl ();

    transfer_counter_reg #(.DATA_W(DW), .MAIN_W(MW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Addr    (addr_w),
        .Bus     (bus_w),
        .MainBus (main_w),
        .ctl     (ctl)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_idle();
        ctl.l_lane_n    = 2'b11;
        ctl.a_lane_n    = 2'b11;
        ctl.l_tx_n      = 1'b1;
        ctl.a_tx_addr_n = 1'b1;
        ctl.a_tx_xfer_n = 1'b1;
        ctl.inc_n       = 1'b1;
        ctl.dec_n       = 1'b1;
        bus_drv_en      = 1'b0;
        main_drv_en     = 1'b0;
    endtask

    typedef struct {
        logic          l_tx_n;
        logic [1:0]    l_lane_n;
        logic          inc_n;
        logic          dec_n;
        logic [DW-1:0] bus_in;
        logic [MW-1:0] main_in;
        logic [DW-1:0] exp_reg;
        logic          exp_zero;
        logic          exp_wrap;
    } vec_t;

    vec_t vecs[10];

    // Apply one row for one edge, then read the register back through Addr.
    task automatic apply_row(input int k);
        ctl.l_tx_n   = vecs[k].l_tx_n;
        ctl.l_lane_n = vecs[k].l_lane_n;
        ctl.inc_n    = vecs[k].inc_n;
        ctl.dec_n    = vecs[k].dec_n;
        bus_drv      = vecs[k].bus_in;
        bus_drv_en   = !vecs[k].l_tx_n;
        main_drv     = vecs[k].main_in;
        main_drv_en  = !(&vecs[k].l_lane_n);
        @(posedge clk); #1;
        set_idle();
        ctl.a_tx_addr_n = 1'b0;
        @(negedge clk);
        check($sformatf("row%0d_addr", k), 32'(addr_w), 32'(vecs[k].exp_reg));
        check($sformatf("row%0d_zero", k), 32'(ctl.zero), 32'(vecs[k].exp_zero));
        check($sformatf("row%0d_wrap", k), 32'(ctl.wrap), 32'(vecs[k].exp_wrap));
        @(posedge clk); #1;
        set_idle();
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) apply_row(k);
    endtask

    // Reference model state
    int m_reg;
    bit m_wrap;
    bit m_conf;

    task automatic model_edge();
        int lanes_low;
        lanes_low = 0;
        if (!ctl.l_tx_n) begin
            m_reg  = int'(bus_drv);
            m_wrap = 0;
        end else if (!(&ctl.l_lane_n)) begin
            for (int i = 0; i < 2; i++) begin
                if (!ctl.l_lane_n[i]) begin
                    m_reg = m_reg - (((m_reg >> (8 * i)) % 256) << (8 * i))
                            + (int'(main_drv) << (8 * i));
                end
            end
            m_wrap = 0;
        end else if (!ctl.inc_n && ctl.dec_n) begin
            m_wrap = (m_reg == 65535);
            m_reg  = (m_reg + 1) % 65536;
        end else if (ctl.inc_n && !ctl.dec_n) begin
            m_wrap = (m_reg == 0);
            m_reg  = (m_reg + 65535) % 65536;
        end else begin
            m_wrap = 0;
        end
        for (int i = 0; i < 2; i++) if (!ctl.a_lane_n[i]) lanes_low++;
        if (lanes_low >= 2) m_conf = 1;
    endtask

    task automatic random_cycle(input int n);
        int r;
        int exp_main;
        ctl.l_tx_n      = ($urandom_range(0, 7) != 0);
        ctl.l_lane_n[0] = ($urandom_range(0, 4) != 0);
        ctl.l_lane_n[1] = ($urandom_range(0, 4) != 0);
        ctl.inc_n       = 1'($urandom_range(0, 1));
        ctl.dec_n       = 1'($urandom_range(0, 1));
        ctl.a_tx_addr_n = 1'($urandom_range(0, 1));
        ctl.a_tx_xfer_n = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 39);
        ctl.a_lane_n = (r == 0) ? 2'b00 : (r < 14) ? 2'b10 : (r < 27) ? 2'b01 : 2'b11;
        bus_drv      = 16'($urandom);
        bus_drv_en   = !ctl.l_tx_n;
        main_drv     = 8'($urandom);
        main_drv_en  = !(&ctl.l_lane_n);
        @(negedge clk);
        check($sformatf("rnd%0d_addr", n), 32'(addr_w), ctl.a_tx_addr_n ? 32'(ZD) : 32'(m_reg));
        if (ctl.l_tx_n)
            check($sformatf("rnd%0d_bus", n), 32'(bus_w), ctl.a_tx_xfer_n ? 32'(ZD) : 32'(m_reg));
        if (!main_drv_en) begin
            if (!ctl.a_lane_n[0]) exp_main = m_reg % 256;
            else if (!ctl.a_lane_n[1]) exp_main = m_reg / 256;
            else exp_main = int'(ZM);
            check($sformatf("rnd%0d_main", n), 32'(main_w), 32'(exp_main));
        end
        check($sformatf("rnd%0d_zero", n), 32'(ctl.zero), 32'(m_reg == 0));
        check($sformatf("rnd%0d_wrap", n), 32'(ctl.wrap), 32'(m_wrap));
        check($sformatf("rnd%0d_conflict", n), 32'(ctl.conflict), 32'(m_conf));
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        //            l_tx  l_lane inc   dec   bus       main   exp_reg   zero  wrap
        vecs[0] = '{1'b1, 2'b01, 1'b1, 1'b1, 16'h0000, 8'h55, 16'h5500, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 2'b10, 1'b1, 1'b1, 16'h0000, 8'hAA, 16'h55AA, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 2'b10, 1'b1, 1'b1, 16'h1234, 8'hFF, 16'h1234, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 2'b00, 1'b0, 1'b1, 16'h0000, 8'h3C, 16'h3C3C, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 2'b11, 1'b0, 1'b1, 16'hFFFF, 8'h00, 16'hFFFF, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 2'b11, 1'b0, 1'b1, 16'h0000, 8'h00, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 2'b11, 1'b1, 1'b0, 16'h0000, 8'h00, 16'hFFFF, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 2'b11, 1'b0, 1'b0, 16'h0000, 8'h00, 16'hFFFF, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 2'b10, 1'b0, 1'b1, 16'h0000, 8'h00, 16'hFF00, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 2'b11, 1'b1, 1'b1, 16'h0100, 8'h00, 16'h0100, 1'b0, 1'b0};

        // Reset state with every driver requested
        set_idle();
        ctl.a_tx_addr_n = 1'b0;
        ctl.a_tx_xfer_n = 1'b0;
        ctl.a_lane_n    = 2'b10;
        @(negedge clk);
        check("rst_addr_z", 32'(addr_w), 32'(ZD));
        check("rst_bus_z", 32'(bus_w), 32'(ZD));
        check("rst_main_z", 32'(main_w), 32'(ZM));
        check("rst_zero", 32'(ctl.zero), 32'd1);
        check("rst_wrap", 32'(ctl.wrap), 32'd0);
        check("rst_conflict", 32'(ctl.conflict), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_addr", 32'(addr_w), 32'h0000);
        @(posedge clk); #1;
        set_idle();

        run_rows(0, 1);
        @(negedge clk);
        check("idle_addr_z", 32'(addr_w), 32'(ZD));
        check("idle_bus_z", 32'(bus_w), 32'(ZD));
        ctl.a_tx_xfer_n = 1'b0;
        #1;
        check("xfer_bus", 32'(bus_w), 32'h55AA);
        @(posedge clk); #1;
        set_idle();

        run_rows(2, 2);
        ctl.a_lane_n = 2'b01;
        #2;
        check("lane1_main", 32'(main_w), 32'h12);
        ctl.l_lane_n = 2'b10;
        #1;
        check("main_off_during_lane_load", 32'(main_w), 32'(ZM));
        ctl.l_lane_n = 2'b11;
        @(posedge clk); #1;
        set_idle();

        run_rows(3, 9);

        // Post-increment: Addr shows the old value until each edge
        ctl.a_tx_addr_n = 1'b0;
        ctl.inc_n       = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("postinc%0d", k), 32'(addr_w), 32'h0100 + 32'(k));
            @(posedge clk); #1;
        end
        ctl.inc_n = 1'b1;
        @(negedge clk);
        check("postinc_final", 32'(addr_w), 32'h0103);
        @(posedge clk); #1;
        set_idle();

        // Two lanes asserted: lowest wins, conflict sticks until reset
        ctl.a_lane_n = 2'b00;
        @(negedge clk);
        check("clash_main", 32'(main_w), 32'h03);
        check("clash_before_edge", 32'(ctl.conflict), 32'd0);
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        check("clash_set", 32'(ctl.conflict), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("clash_sticky", 32'(ctl.conflict), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("clash_cleared", 32'(ctl.conflict), 32'd0);
        check("clash_rst_zero", 32'(ctl.zero), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a wrapping count
        run_rows(4, 4);
        ctl.inc_n       = 1'b0;
        ctl.a_tx_xfer_n = 1'b0;
        @(posedge clk); #1;
        check("midcnt_wrap", 32'(ctl.wrap), 32'd1);
        check("midcnt_bus", 32'(bus_w), 32'h0000);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_bus_z", 32'(bus_w), 32'(ZD));
        check("midrst_wrap", 32'(ctl.wrap), 32'd0);
        check("midrst_zero", 32'(ctl.zero), 32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("resume_bus", 32'(bus_w), 32'h0001);
        check("resume_zero", 32'(ctl.zero), 32'd0);

        // Randomized run from a fresh reset
        #1 rst_n = 1'b0;
        set_idle();
        m_reg  = 0;
        m_wrap = 0;
        m_conf = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 400; n++) random_cycle(n);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
